c_mod_stream_arbiter: RTL and testbench
=======================================

C_MOD_STREAM_ARBITER -- requirements
Module: c_mod_stream_arbiter

Interface
REQ-001 Parameter DATA_W, default 8, the data width of each source and of the output beat.
REQ-002 Parameter MAX_LEN, default 1024, the maximum beats per output packet; minimum legal value is 2.
REQ-003 Port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 Port reset, input, 1, synchronous, active-high reset.
REQ-005 Ports s0_valid/s0_sop/s0_eop, input, 1 each: Avalon-ST source 0 valid, start-of-packet and end-of-packet.
REQ-006 Port s0_data, input, DATA_W: source 0 data.
REQ-007 Port s0_ready, output, 1: source 0 ready.
REQ-008 Ports s1_valid/s1_sop/s1_eop/s1_data/s1_ready are identical in width and meaning for source 1.
REQ-009 Ports out_valid/out_sop/out_eop, output, 1 each; out_data, output, DATA_W. These drive the c_mod_input sink, which has no ready signal.
REQ-010 Port pkt_count, output, 16: number of packets completed with a natural EOP.
REQ-011 Port trunc_count, output, 16: number of packets truncated at MAX_LEN.

Function
REQ-012 The block SHALL have three states: IDLE, XFER and DRAIN, plus a 1-bit grant register and a 1-bit last_grant register.
REQ-013 In IDLE, both sX_ready outputs SHALL be 0.
REQ-014 In IDLE, if any sX_valid is 1, the block SHALL latch grant on the next edge and enter XFER.
REQ-015 If both sources are valid in IDLE, the grant SHALL go to the source that is not last_grant (round-robin); otherwise it goes to the sole requester.
REQ-016 In XFER and DRAIN, sX_ready SHALL be 1 for the granted source and 0 for the other; a beat transfers when valid & ready.
REQ-017 A transferred beat in XFER SHALL appear on out_* exactly 1 cycle later (registered).
- out_valid is 1 for that single cycle only.
- out_valid is 0 in every cycle in which no beat was forwarded.
REQ-018 out_sop SHALL be 1 only on the first forwarded beat of a packet; an input sop on any later beat SHALL be ignored and forwarded as data.
REQ-019 If the first beat transferred in XFER lacks sop (stray beat), it SHALL NOT be forwarded, and the state SHALL go to DRAIN.
REQ-020 A beat counter SHALL count forwarded beats per packet. When it would reach MAX_LEN on a non-eop beat:
- the block SHALL emit that beat with out_eop=1;
- increment trunc_count;
- enter DRAIN.
REQ-021 On an eop beat in XFER within the length limit, the block SHALL:
- forward it with out_eop=1;
- increment pkt_count;
- set last_grant=grant;
- return to IDLE.
REQ-022 A single beat with both sop and eop SHALL produce out_sop=out_eop=1 in the same cycle.
REQ-023 In DRAIN, granted-source beats SHALL be accepted and discarded; on the eop beat the block SHALL set last_grant=grant and enter IDLE.
REQ-024 A minimum of 1 IDLE cycle SHALL separate consecutive packets; the non-granted source SHALL never see ready=1.
REQ-025 pkt_count and trunc_count SHALL wrap modulo 2^16.

Reset
REQ-026 On reset, the block SHALL:
- set state to IDLE and grant to 0;
- set last_grant to 1, so source 0 wins the first tie;
- clear the beat counter;
- drive out_valid/out_sop/out_eop/out_data, both counters and both sX_ready to 0.
REQ-027 Reset asserted mid-packet SHALL zero the outputs on that edge, with no EOP emitted and the packet abandoned.

Structure
REQ-028 A shared package c_mod_stream_pkg SHALL hold the state enum and the DATA_W and MAX_LEN defaults.
REQ-029 Round-robin grant selection SHALL be a sub-module c_mod_rr_arb2 with inputs req[1:0] and last_grant, and output grant.

Verification
REQ-030 Source 0 sends a 4-beat packet 0x10..0x13 -> out_* show 0x10(sop) … 0x13(eop), each 1 cycle after transfer; pkt_count=1.
REQ-031 Both sources present a 2-beat packet from reset -> source 0 is served first, then source 1 after 1 IDLE cycle; pkt_count=2.
REQ-032 MAX_LEN=4, source 1 sends a 6-beat packet -> 4 beats are output, the 4th with eop; 2 beats are dropped; trunc_count=1; state returns to IDLE after the input eop.
REQ-033 Source 0 sends a beat without sop followed by an eop beat -> no out_valid; state returns to IDLE; both counters stay 0.
REQ-034 Reset asserted on the 2nd beat of a 3-beat packet -> out_valid is 0 the next cycle; a subsequent clean packet is forwarded normally with sop.

Source files
------------

// File: rtl/c_mod_stream_pkg.sv
// Shared types and defaults for the two-source stream arbiter.
package c_mod_stream_pkg;

    localparam int unsigned DATA_W_DEF  = 8;
    localparam int unsigned MAX_LEN_DEF = 1024;
    localparam int unsigned CNT_W       = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_XFER  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/c_mod_rr_arb2.sv
// Two-requester round-robin selector: on a tie the source that did not win last time is picked.
module c_mod_rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       grant
);

    // Tie goes to the non-last winner; otherwise the sole requester (0 when idle).
    always_comb begin
        grant = 1'b0;
        if (req == 2'b11) begin
            grant = ~last_grant;
        end else if (req[1]) begin
            grant = 1'b1;
        end
    end

endmodule

// File: rtl/c_mod_stream_arbiter.sv
// Packet-level arbiter merging two Avalon-ST sources onto a ready-less sink,
// with truncation at MAX_LEN beats and discard of stray (sop-less) packets.
module c_mod_stream_arbiter
    import c_mod_stream_pkg::*;
#(
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned MAX_LEN = MAX_LEN_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              s0_valid,
    input  logic              s0_sop,
    input  logic              s0_eop,
    input  logic [DATA_W-1:0] s0_data,
    output logic              s0_ready,
    input  logic              s1_valid,
    input  logic              s1_sop,
    input  logic              s1_eop,
    input  logic [DATA_W-1:0] s1_data,
    output logic              s1_ready,
    output logic              out_valid,
    output logic              out_sop,
    output logic              out_eop,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  pkt_count,
    output logic [CNT_W-1:0]  trunc_count
);

    localparam int unsigned BEAT_W = $clog2(MAX_LEN + 1);

    state_t              state_q, state_d;
    logic                grant_q, grant_d;
    logic                last_grant_q, last_grant_d;
    logic [BEAT_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic                s0_ready_q, s0_ready_d;
    logic                s1_ready_q, s1_ready_d;
    logic                out_valid_q, out_valid_d;
    logic                out_sop_q, out_sop_d;
    logic                out_eop_q, out_eop_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic [CNT_W-1:0]    pkt_count_q, pkt_count_d;
    logic [CNT_W-1:0]    trunc_count_q, trunc_count_d;

    logic                arb_grant;
    logic                g_valid, g_sop, g_eop, g_ready, beat_fire;
    logic [DATA_W-1:0]   g_data;
    logic                first_beat, at_limit;

    c_mod_rr_arb2 u_rr_arb2 (
        .req        ({s1_valid, s0_valid}),
        .last_grant (last_grant_q),
        .grant      (arb_grant)
    );

    // Select the granted source's handshake and payload.
    always_comb begin
        g_valid   = grant_q ? s1_valid   : s0_valid;
        g_sop     = grant_q ? s1_sop     : s0_sop;
        g_eop     = grant_q ? s1_eop     : s0_eop;
        g_data    = grant_q ? s1_data    : s0_data;
        g_ready   = grant_q ? s1_ready_q : s0_ready_q;
        beat_fire = g_valid & g_ready;
        first_beat = (beat_cnt_q == '0);
        at_limit   = ((beat_cnt_q + BEAT_W'(1)) == BEAT_W'(MAX_LEN));
    end

    // Next-state, forwarding and counter logic.
    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        last_grant_d  = last_grant_q;
        beat_cnt_d    = beat_cnt_q;
        out_valid_d   = 1'b0;
        out_sop_d     = 1'b0;
        out_eop_d     = 1'b0;
        out_data_d    = out_data_q;
        pkt_count_d   = pkt_count_q;
        trunc_count_d = trunc_count_q;

        unique case (state_q)
            ST_IDLE: begin
                beat_cnt_d = '0;
                if (s0_valid || s1_valid) begin
                    grant_d = arb_grant;
                    state_d = ST_XFER;
                end
            end
            ST_XFER: begin
                if (beat_fire) begin
                    if (first_beat && !g_sop) begin
                        // A stray beat that also ends the packet leaves nothing to drain.
                        if (g_eop) begin
                            last_grant_d = grant_q;
                            state_d      = ST_IDLE;
                        end else begin
                            state_d = ST_DRAIN;
                        end
                    end else begin
                        out_valid_d = 1'b1;
                        out_sop_d   = first_beat;
                        out_data_d  = g_data;
                        beat_cnt_d  = beat_cnt_q + BEAT_W'(1);
                        if (g_eop) begin
                            out_eop_d    = 1'b1;
                            pkt_count_d  = pkt_count_q + CNT_W'(1);
                            last_grant_d = grant_q;
                            state_d      = ST_IDLE;
                        end else if (at_limit) begin
                            out_eop_d     = 1'b1;
                            trunc_count_d = trunc_count_q + CNT_W'(1);
                            state_d       = ST_DRAIN;
                        end
                    end
                end
            end
            ST_DRAIN: begin
                if (beat_fire && g_eop) begin
                    last_grant_d = grant_q;
                    state_d      = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Ready follows the upcoming state so it is already valid in the first XFER cycle.
        s0_ready_d = (state_d != ST_IDLE) && !grant_d;
        s1_ready_d = (state_d != ST_IDLE) &&  grant_d;
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            grant_q       <= 1'b0;
            last_grant_q  <= 1'b1;
            beat_cnt_q    <= '0;
            s0_ready_q    <= 1'b0;
            s1_ready_q    <= 1'b0;
            out_valid_q   <= 1'b0;
            out_sop_q     <= 1'b0;
            out_eop_q     <= 1'b0;
            out_data_q    <= '0;
            pkt_count_q   <= '0;
            trunc_count_q <= '0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            last_grant_q  <= last_grant_d;
            beat_cnt_q    <= beat_cnt_d;
            s0_ready_q    <= s0_ready_d;
            s1_ready_q    <= s1_ready_d;
            out_valid_q   <= out_valid_d;
            out_sop_q     <= out_sop_d;
            out_eop_q     <= out_eop_d;
            out_data_q    <= out_data_d;
            pkt_count_q   <= pkt_count_d;
            trunc_count_q <= trunc_count_d;
        end
    end

    assign s0_ready    = s0_ready_q;
    assign s1_ready    = s1_ready_q;
    assign out_valid   = out_valid_q;
    assign out_sop     = out_sop_q;
    assign out_eop     = out_eop_q;
    assign out_data    = out_data_q;
    assign pkt_count   = pkt_count_q;
    assign trunc_count = trunc_count_q;

endmodule

// File: tb/tb_c_mod_stream_arbiter.sv
// Scoreboard bench for c_mod_stream_arbiter built with MAX_LEN=4.
module tb_c_mod_stream_arbiter;

    localparam int unsigned DW = 8;
    localparam int          ML = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          s0_valid, s0_sop, s0_eop, s0_ready;
    logic [DW-1:0] s0_data;
    logic          s1_valid, s1_sop, s1_eop, s1_ready;
    logic [DW-1:0] s1_data;
    logic          out_valid, out_sop, out_eop;
    logic [DW-1:0] out_data;
    logic [15:0]   pkt_count, trunc_count;

    typedef struct packed {
        logic [7:0] data;
        logic       sop;
        logic       eop;
    } beat_t;

    beat_t exp_q[$];
    int    n_checks  = 0;
    int    n_errors  = 0;
    int    exp_pkt   = 0;
    int    exp_trunc = 0;
    logic  prev_xfer = 1'b0;
    time   sop_t[2];
    time   eop_t[2];

    always #5 clk = ~clk;

    c_mod_stream_arbiter #(.DATA_W(DW), .MAX_LEN(ML)) u_dut (
        .clk         (clk),
        .reset       (reset),
        .s0_valid    (s0_valid),
        .s0_sop      (s0_sop),
        .s0_eop      (s0_eop),
        .s0_data     (s0_data),
        .s0_ready    (s0_ready),
        .s1_valid    (s1_valid),
        .s1_sop      (s1_sop),
        .s1_eop      (s1_eop),
        .s1_data     (s1_data),
        .s1_ready    (s1_ready),
        .out_valid   (out_valid),
        .out_sop     (out_sop),
        .out_eop     (out_eop),
        .out_data    (out_data),
        .pkt_count   (pkt_count),
        .trunc_count (trunc_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic drive_src(input int src, input logic v, input logic s, input logic e,
                             input logic [7:0] d);
        if (src == 0) begin
            s0_valid = v; s0_sop = s; s0_eop = e; s0_data = d;
        end else begin
            s1_valid = v; s1_sop = s; s1_eop = e; s1_data = d;
        end
    endtask

    function automatic logic src_ready(input int src);
        return (src == 0) ? s0_ready : s1_ready;
    endfunction

    // Drive one packet; expected output beats are queued as each beat is accepted.
    task automatic send_pkt(input int src, input logic [7:0] base, input int len,
                            input logic with_sop);
        int    wait_cnt;
        beat_t b;
        for (int i = 0; i < len; i++) begin
            drive_src(src, 1'b1, with_sop && (i == 0), i == len - 1, base + 8'(i));
            wait_cnt = 0;
            @(negedge clk);
            while (!src_ready(src) && wait_cnt < 200) begin
                @(negedge clk);
                wait_cnt++;
            end
            if (!src_ready(src)) begin
                check("handshake_timeout", 32'(src_ready(src)), 32'd1);
                drive_src(src, 1'b0, 1'b0, 1'b0, 8'h00);
                return;
            end
            @(posedge clk);
            if (i == 0)       sop_t[src] = $time;
            if (i == len - 1) eop_t[src] = $time;
            if (with_sop && i < ML) begin
                b.data = base + 8'(i);
                b.sop  = (i == 0);
                b.eop  = (i == len - 1) || (i == ML - 1);
                exp_q.push_back(b);
            end
            #1;
        end
        drive_src(src, 1'b0, 1'b0, 1'b0, 8'h00);
        if (with_sop) begin
            if (len <= ML) exp_pkt++;
            else           exp_trunc++;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive_src(0, 1'b0, 1'b0, 1'b0, 8'h00);
        drive_src(1, 1'b0, 1'b0, 1'b0, 8'h00);
        repeat (3) @(posedge clk);
        exp_q.delete();
        exp_pkt   = 0;
        exp_trunc = 0;
        #1 reset = 1'b0;
    endtask

    task automatic idle_check(input string tag);
        repeat (3) @(negedge clk);
        check({tag, "_pkt_count"},   32'(pkt_count),   32'(exp_pkt));
        check({tag, "_trunc_count"}, 32'(trunc_count), 32'(exp_trunc));
        check({tag, "_ready_idle"},  32'({s0_ready, s1_ready}), 32'd0);
    endtask

    // Output monitor: every out_valid must follow a transfer and match the scoreboard head.
    always @(negedge clk) begin
        beat_t b;
        if (reset) begin
            prev_xfer = 1'b0;
        end else begin
            if (s0_ready && s1_ready) check("ready_exclusive", 32'd1, 32'd0);
            if (out_valid) begin
                check("latency", 32'(prev_xfer), 32'd1);
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 32'(exp_q.size()), 32'd1);
                end else begin
                    b = exp_q.pop_front();
                    check("out_data", 32'(out_data), 32'(b.data));
                    check("out_sop",  32'(out_sop),  32'(b.sop));
                    check("out_eop",  32'(out_eop),  32'(b.eop));
                end
            end
            prev_xfer = (s0_valid && s0_ready) || (s1_valid && s1_ready);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish expected finish by %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int wait_cnt;
        beat_t b;

        // Reset state
        do_reset();
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_sop",   32'(out_sop),   32'd0);
        check("rst_out_eop",   32'(out_eop),   32'd0);
        check("rst_out_data",  32'(out_data),  32'd0);
        check("rst_ready",     32'({s0_ready, s1_ready}), 32'd0);
        check("rst_counts",    32'({pkt_count, trunc_count}), 32'd0);
        #1 reset = 1'b0;

        // Four-beat packet from source 0
        send_pkt(0, 8'h10, 4, 1'b1);
        idle_check("t4beat");

        // Both sources contend from reset: source 0 first, then source 1 after an idle cycle
        do_reset();
        fork
            send_pkt(0, 8'h20, 2, 1'b1);
            send_pkt(1, 8'h30, 2, 1'b1);
        join
        check("rr_order", 32'(sop_t[0] < sop_t[1]), 32'd1);
        check("idle_gap", 32'((sop_t[1] - eop_t[0]) >= 20), 32'd1);
        idle_check("trr");

        // Truncation: 6-beat packet on source 1 with MAX_LEN=4
        do_reset();
        send_pkt(1, 8'h60, 6, 1'b1);
        idle_check("ttrunc");

        // Stray beat without sop followed by an eop beat is discarded
        do_reset();
        send_pkt(0, 8'h70, 2, 1'b0);
        idle_check("tstray");

        // Single beat carrying both sop and eop, then a tie after source 1 won last
        send_pkt(1, 8'h80, 1, 1'b1);
        idle_check("tsingle");
        fork
            send_pkt(0, 8'h90, 1, 1'b1);
            send_pkt(1, 8'hA0, 1, 1'b1);
        join
        check("rr_tie_src0", 32'(sop_t[0] < sop_t[1]), 32'd1);
        idle_check("ttie");

        // Reset on the second beat of a three-beat packet
        do_reset();
        drive_src(0, 1'b1, 1'b1, 1'b0, 8'h40);
        wait_cnt = 0;
        @(negedge clk);
        while (!s0_ready && wait_cnt < 200) begin
            @(negedge clk);
            wait_cnt++;
        end
        check("rst_mid_handshake", 32'(s0_ready), 32'd1);
        @(posedge clk);
        b.data = 8'h40; b.sop = 1'b1; b.eop = 1'b0;
        exp_q.push_back(b);
        #1 drive_src(0, 1'b1, 1'b0, 1'b0, 8'h41);
        @(negedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rst_mid_out_valid", 32'(out_valid), 32'd0);
        check("rst_mid_out_eop",   32'(out_eop),   32'd0);
        check("rst_mid_ready",     32'({s0_ready, s1_ready}), 32'd0);
        reset = 1'b0;
        drive_src(0, 1'b0, 1'b0, 1'b0, 8'h00);
        exp_pkt   = 0;
        exp_trunc = 0;
        @(posedge clk);
        #1;
        send_pkt(0, 8'h50, 3, 1'b1);
        idle_check("tpost_rst");

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
